// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Data-memory front end between the execute stage and a
//            single-ported, word-indexed RAM. Converts RV32I loads/stores
//            (LB/LH/LW/LBU/LHU/SB/SH/SW) into RAM strobes, extracts and
//            extends load lanes, performs sub-word stores as
//            read-modify-write, and stalls the core until the access is done.
// Ports    : clk, nRst            - clock, async active-low reset
//            req_load, req_store  - requests, held by the core until stall drops
//            funct3, addr         - RV32I width/sign code, byte address
//            store_data           - store operand
//            load_data, fault     - results, valid in DONE
//            stall                - high while an accepted request is incomplete
//            mem_read_enable,
//            mem_write_enable,
//            mem_address,
//            mem_wdata, mem_rdata - RAM side (registered read data)
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       store_data,
  output logic [31:0]       load_data,
  output logic              stall,
  output logic              fault,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [ADDR_W-1:0]  r_addr;
  logic [2:0]         r_funct3;
  logic [15:0]        r_sdata;
  logic               r_is_load;
  logic [31:0]        r_load_data;
  logic               r_fault;
  logic [31:0]        r_wbuf;

  // Address bits above the RAM window wrap, so they are deliberately dropped.
  logic               w_unused_addr_hi;
  assign w_unused_addr_hi = ^addr[31:ADDR_W];

  // A request only counts while out of reset, so an asserted reset forces
  // every combinational output to its idle value even if the core still
  // holds a request.
  logic w_req;
  assign w_req = (req_load | req_store) & nRst;

  // ---------------------------------------------------------------- decode
  logic w_both;
  logic w_illegal;
  logic w_misalign;
  logic w_fault;
  logic w_is_sw;

  assign w_both     = req_load & req_store;
  assign w_illegal  = req_load ? ((funct3 == 3'b011) || (funct3[2:1] == 2'b11))
                               : (funct3 >= 3'b011);
  assign w_misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  assign w_fault    = w_both | w_illegal | w_misalign;
  assign w_is_sw    = req_store & ~req_load & (funct3 == 3'b010);

  // ------------------------------------------------- load lane extraction
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  always_comb begin
    w_byte = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
    w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_ext = {24'd0, w_byte};
      3'b101:  w_ext = {16'd0, w_half};
      default: w_ext = mem_rdata;
    endcase
  end

  // ------------------------------------------------- sub-word store merge
  logic [31:0] w_merged;

  always_comb begin
    w_merged = mem_rdata;
    if (r_funct3 == 3'b000) begin
      w_merged[{r_addr[1:0], 3'b000} +: 8] = r_sdata[7:0];
    end else if (r_addr[1]) begin
      w_merged[31:16] = r_sdata;
    end else begin
      w_merged[15:0] = r_sdata;
    end
  end

  // ------------------------------------------- next state and RAM strobes
  always_comb begin
    w_next           = r_state;
    stall            = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_address      = '0;
    mem_wdata        = '0;
    case (r_state)
      S_IDLE: begin
        if (nRst) begin
          mem_address = {addr[ADDR_W-1:2], 2'b00};
        end
        if (w_req) begin
          stall = 1'b1;
          if (w_fault) begin
            w_next = S_DONE;
          end else if (w_is_sw) begin
            mem_write_enable = 1'b1;
            mem_wdata        = store_data;
            w_next           = S_DONE;
          end else begin
            mem_read_enable = 1'b1;
            w_next          = S_RD;
          end
        end
      end
      S_RD: begin
        stall       = 1'b1;
        mem_address = {r_addr[ADDR_W-1:2], 2'b00};
        w_next      = r_is_load ? S_DONE : S_WR;
      end
      S_WR: begin
        stall            = 1'b1;
        mem_address      = {r_addr[ADDR_W-1:2], 2'b00};
        mem_write_enable = 1'b1;
        mem_wdata        = r_wbuf;
        w_next           = S_DONE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------ registers
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_funct3    <= 3'b000;
      r_sdata     <= 16'd0;
      r_is_load   <= 1'b0;
      r_load_data <= 32'd0;
      r_fault     <= 1'b0;
      r_wbuf      <= 32'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr      <= addr[ADDR_W-1:0];
            r_funct3    <= funct3;
            r_sdata     <= store_data[15:0];
            r_is_load   <= req_load;
            r_fault     <= w_fault;
            r_load_data <= 32'd0;
          end
        end
        S_RD: begin
          if (r_is_load) begin
            r_load_data <= w_ext;
          end else begin
            r_wbuf <= w_merged;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign load_data = r_load_data;
  assign fault     = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed self-checking bench for load_store_unit with a
//            registered-read word RAM model attached to the memory port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        req_load = 1'b0;
  logic        req_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic [31:0] load_data;
  logic        stall;
  logic        fault;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [11:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  load_store_unit #(.ADDR_W(12)) dut (
    .clk              (clk),
    .nRst             (nRst),
    .req_load         (req_load),
    .req_store        (req_store),
    .funct3           (funct3),
    .addr             (addr),
    .store_data       (store_data),
    .load_data        (load_data),
    .stall            (stall),
    .fault            (fault),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata)
  );

  always #5 clk = ~clk;

  // Word RAM: registered read, whole-word write.
  logic [31:0] mem [0:1023];
  int          rd_cnt = 0;
  int          wr_cnt = 0;

  always @(posedge clk) begin
    if (mem_write_enable) begin
      mem[mem_address[11:2]] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_read_enable) begin
      mem_rdata <= mem[mem_address[11:2]];
      rd_cnt <= rd_cnt + 1;
    end
  end

  int checks = 0;
  int failures = 0;

  int          res_cycles;
  logic [31:0] res_load;
  logic        res_fault;
  int          res_rd;
  int          res_wr;
  logic        res_first_we;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request at a falling edge and hold it until stall drops.
  task automatic do_req(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd);
    int rd0;
    int wr0;
    @(negedge clk);
    rd0        = rd_cnt;
    wr0        = wr_cnt;
    req_load   = ld;
    req_store  = st;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    #1;
    res_first_we = mem_write_enable;
    res_cycles   = 1;
    while (stall && res_cycles < 20) begin
      @(negedge clk);
      res_cycles++;
    end
    res_load  = load_data;
    res_fault = fault;
    res_rd    = rd_cnt - rd0;
    res_wr    = wr_cnt - wr0;
    req_load  = 1'b0;
    req_store = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // ---------------------------------------------------------- reset
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_ld", load_data, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_strobes", {30'd0, mem_read_enable, mem_write_enable}, 32'd0);
    check("rst_maddr", {20'd0, mem_address}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);

    // -------------------------------------------- preload via SW
    do_req(1'b0, 1'b1, 3'b010, 32'h8000_0040, 32'h1234_F680);
    check("sw_pre_cycles", res_cycles, 32'd2);
    check("sw_pre_first_we", {31'd0, res_first_we}, 32'd1);
    check("sw_pre_mem", mem[10'h010], 32'h1234_F680);
    do_req(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hAABB_CCDD);
    do_req(1'b0, 1'b1, 3'b010, 32'h0000_0004, 32'h0BAD_F00D);
    do_req(1'b0, 1'b1, 3'b010, 32'h0000_0200, 32'h1111_2222);
    do_req(1'b0, 1'b1, 3'b010, 32'h0000_0000, 32'h5A5A_A5A5);

    // -------------------------------------------- load extension
    do_req(1'b1, 1'b0, 3'b000, 32'h0000_0041, 32'd0);
    check("lb_val", res_load, 32'hFFFF_FFF6);
    check("lb_cycles", res_cycles, 32'd3);
    check("lb_reads", res_rd, 32'd1);
    do_req(1'b1, 1'b0, 3'b100, 32'h0000_0041, 32'd0);
    check("lbu_val", res_load, 32'h0000_00F6);
    do_req(1'b1, 1'b0, 3'b001, 32'h0000_0042, 32'd0);
    check("lh_val", res_load, 32'h0000_1234);
    check("lh_cycles", res_cycles, 32'd3);
    do_req(1'b1, 1'b0, 3'b001, 32'h0000_0040, 32'd0);
    check("lh_neg_val", res_load, 32'hFFFF_F680);
    do_req(1'b1, 1'b0, 3'b101, 32'h0000_0040, 32'd0);
    check("lhu_val", res_load, 32'h0000_F680);
    do_req(1'b1, 1'b0, 3'b000, 32'h0000_0043, 32'd0);
    check("lb_pos_val", res_load, 32'h0000_0012);
    do_req(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'd0);
    check("lw_val", res_load, 32'h1234_F680);
    check("lw_fault", {31'd0, res_fault}, 32'd0);

    // -------------------------------------------- SB read-modify-write
    do_req(1'b0, 1'b1, 3'b000, 32'h0000_0102, 32'h1234_5655);
    check("sb_cycles", res_cycles, 32'd4);
    check("sb_reads", res_rd, 32'd1);
    check("sb_writes", res_wr, 32'd1);
    do_req(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0);
    check("sb_lw_val", res_load, 32'hAA55_CCDD);
    do_req(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'hFFFF_9876);
    check("sh_cycles", res_cycles, 32'd4);
    check("sh_mem", mem[10'h040], 32'h9876_CCDD);

    // -------------------------------------------- SW and wrap
    do_req(1'b0, 1'b1, 3'b010, 32'h0000_07FC, 32'hDEAD_BEEF);
    check("sw_cycles", res_cycles, 32'd2);
    check("sw_first_we", {31'd0, res_first_we}, 32'd1);
    check("sw_reads", res_rd, 32'd0);
    do_req(1'b1, 1'b0, 3'b010, 32'h1000_07FC, 32'd0);
    check("sw_wrap_lw", res_load, 32'hDEAD_BEEF);

    // -------------------------------------------- misalignment faults
    do_req(1'b1, 1'b0, 3'b010, 32'h0000_0002, 32'd0);
    check("lw_mis_fault", {31'd0, res_fault}, 32'd1);
    check("lw_mis_ld", res_load, 32'd0);
    check("lw_mis_cycles", res_cycles, 32'd2);
    check("lw_mis_strobes", res_rd + res_wr, 32'd0);
    do_req(1'b0, 1'b1, 3'b001, 32'h0000_0005, 32'h0000_7777);
    check("sh_mis_fault", {31'd0, res_fault}, 32'd1);
    check("sh_mis_strobes", res_rd + res_wr, 32'd0);
    check("sh_mis_mem", mem[10'h001], 32'h0BAD_F00D);
    do_req(1'b1, 1'b0, 3'b001, 32'h0000_0003, 32'd0);
    check("lh_mis_fault", {31'd0, res_fault}, 32'd1);
    check("lh_mis_ld", res_load, 32'd0);

    // -------------------------------------------- illegal requests
    do_req(1'b1, 1'b1, 3'b010, 32'h0000_0000, 32'h0000_0001);
    check("both_fault", {31'd0, res_fault}, 32'd1);
    check("both_strobes", res_rd + res_wr, 32'd0);
    check("both_mem", mem[10'h000], 32'h5A5A_A5A5);
    do_req(1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'd0);
    check("ld_f3_fault", {31'd0, res_fault}, 32'd1);
    do_req(1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'd0);
    check("st_f3_fault", {31'd0, res_fault}, 32'd1);
    check("st_f3_strobes", res_rd + res_wr, 32'd0);
    do_req(1'b1, 1'b0, 3'b000, 32'h0000_0000, 32'd0);
    check("post_fault_lb", res_load, 32'hFFFF_FFA5);
    check("post_fault_ok", {31'd0, res_fault}, 32'd0);

    // -------------------------------------------- reset during WR
    @(negedge clk);
    req_store  = 1'b1;
    funct3     = 3'b001;
    addr       = 32'h0000_0200;
    store_data = 32'h0000_7777;
    @(negedge clk);            // RD
    @(negedge clk);            // WR
    check("wr_state_we", {31'd0, mem_write_enable}, 32'd1);
    nRst = 1'b0;
    #1;
    check("rst_wr_stall", {31'd0, stall}, 32'd0);
    check("rst_wr_strobes", {30'd0, mem_read_enable, mem_write_enable}, 32'd0);
    check("rst_wr_maddr", {20'd0, mem_address}, 32'd0);
    check("rst_wr_wdata", mem_wdata, 32'd0);
    check("rst_wr_ld", load_data, 32'd0);
    check("rst_wr_fault", {31'd0, fault}, 32'd0);
    @(negedge clk);
    req_store = 1'b0;
    @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);
    check("rst_wr_idle_stall", {31'd0, stall}, 32'd0);
    check("rst_wr_mem", mem[10'h080], 32'h1111_2222);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
